// File: rtl/bitserial_mac_array_if.sv
`default_nettype none
// ============================================================================
// Module      : bitserial_mac_array_if
// Description : Handshake bundle for the bit-serial MAC array.
//               master : the side driving start/neurons/weight beats and
//                        out_ready (neuron buffer + activation stage).
//               slave  : the MAC array itself.
//               Signals:
//                 start, neuron_in      operation launch + latched neurons
//                 in_ready              array idle, start may be accepted
//                 bit_valid, weight_bit one weight bit per lane per beat
//                 busy                  accumulating or summing
//                 out_valid, out_ready  result handshake
//                 result, sat           saturated sum and clip flag
// Revision    : 1.0  initial release
// ============================================================================
interface bitserial_mac_array_if #(
    parameter int LANES = 16,
    parameter int DW    = 16,
    parameter int OW    = 16
);
    logic                  start;
    logic [LANES*DW-1:0]   neuron_in;
    logic                  in_ready;
    logic                  bit_valid;
    logic [LANES-1:0]      weight_bit;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [OW-1:0]         result;
    logic                  sat;

    modport master (
        output start, neuron_in, bit_valid, weight_bit, out_ready,
        input  in_ready, busy, out_valid, result, sat
    );

    modport slave (
        input  start, neuron_in, bit_valid, weight_bit, out_ready,
        output in_ready, busy, out_valid, result, sat
    );
endinterface
`default_nettype wire

// File: rtl/bitserial_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : bitserial_mac_array
// Description : Bit-serial signed multiply-accumulate array. LANES neurons are
//               latched on start; each lane's weight then arrives LSB first,
//               one bit per beat. Lane products are summed by an adder tree,
//               shifted right by FRAC (floor), saturated to OW bits and
//               presented with a valid/ready handshake.
//               Ports:
//                 clk  rising-edge clock
//                 rst  synchronous active-high reset
//                 bus  bitserial_mac_array_if.slave handshake bundle
// Revision    : 1.0  initial release
// ============================================================================
module bitserial_mac_array #(
    parameter int LANES = 16,
    parameter int DW    = 16,
    parameter int WW    = 16,
    parameter int FRAC  = 8,
    parameter int OW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bitserial_mac_array_if.slave bus
);

    // Per-lane accumulator holds an exact DW x WW product; the tree adds
    // clog2(LANES) guard bits so the total never overflows.
    localparam int c_aw = DW + WW;
    localparam int c_lg = $clog2(LANES);
    localparam int c_sw = c_aw + c_lg;
    localparam int c_cw = $clog2(WW);
    localparam int c_nodes = 2 * LANES - 1;

    localparam logic [c_cw-1:0]        c_last_bit = c_cw'(WW - 1);
    localparam logic signed [c_sw-1:0] c_sat_max  =
        $signed({{(c_sw - OW + 1){1'b0}}, {(OW - 1){1'b1}}});
    localparam logic signed [c_sw-1:0] c_sat_min  =
        $signed({{(c_sw - OW + 1){1'b1}}, {(OW - 1){1'b0}}});

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SUM   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_busy;
    logic                    r_out_valid;
    logic [OW-1:0]           r_result;
    logic                    r_sat;
    logic [c_cw-1:0]         r_bit_cnt;
    logic signed [DW-1:0]    r_neuron [LANES];
    logic signed [c_aw-1:0]  r_acc    [LANES];

    logic signed [c_aw-1:0]  w_term   [LANES];
    logic signed [c_sw-1:0]  w_tree   [c_nodes];
    logic signed [c_sw-1:0]  w_shift;
    logic                    w_clip_hi;
    logic                    w_clip_lo;
    logic [OW-1:0]           w_sat_val;

    // Partial product for the current beat: sign-extended neuron shifted by
    // the bit index. The sign-bit beat subtracts this same term.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_term[k] = {{WW{r_neuron[k][DW-1]}}, r_neuron[k]} << r_bit_cnt;
        end
    end

    // Heap-ordered adder tree: leaves at [LANES-1 .. 2*LANES-2], node n sums
    // children 2n+1 and 2n+2, root at index 0.
    always_comb begin
        for (int n = 0; n < c_nodes; n++) begin
            w_tree[n] = '0;
        end
        for (int k = 0; k < LANES; k++) begin
            w_tree[LANES - 1 + k] = {{c_lg{r_acc[k][c_aw-1]}}, r_acc[k]};
        end
        for (int n = LANES - 2; n >= 0; n--) begin
            w_tree[n] = w_tree[2 * n + 1] + w_tree[2 * n + 2];
        end
    end

    // Arithmetic shift floors toward -inf, then clip to the OW range.
    always_comb begin
        w_shift   = w_tree[0] >>> FRAC;
        w_clip_hi = (w_shift > c_sat_max);
        w_clip_lo = (w_shift < c_sat_min);
        if (w_clip_hi) begin
            w_sat_val = c_sat_max[OW-1:0];
        end else if (w_clip_lo) begin
            w_sat_val = c_sat_min[OW-1:0];
        end else begin
            w_sat_val = w_shift[OW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_sat       <= 1'b0;
            r_bit_cnt   <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_acc[k]    <= '0;
                r_neuron[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < LANES; k++) begin
                            r_neuron[k] <= bus.neuron_in[k*DW +: DW];
                            r_acc[k]    <= '0;
                        end
                        r_bit_cnt  <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (bus.bit_valid) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (bus.weight_bit[k]) begin
                                r_acc[k] <= (r_bit_cnt == c_last_bit) ?
                                            r_acc[k] - w_term[k] :
                                            r_acc[k] + w_term[k];
                            end
                        end
                        r_bit_cnt <= r_bit_cnt + c_cw'(1);
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= S_SUM;
                        end
                    end
                end
                S_SUM: begin
                    r_result    <= w_sat_val;
                    r_sat       <= w_clip_hi | w_clip_lo;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_bitserial_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitserial_mac_array
// Description : Directed, table-driven bench for bitserial_mac_array. One
//               instance with default parameters, one small instance
//               (LANES=4, DW=8, WW=8, FRAC=4, OW=12).
// Revision    : 1.0  initial release
// ============================================================================
module tb_bitserial_mac_array;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bitserial_mac_array_if #(.LANES(16), .DW(16), .OW(16)) a_if ();
    bitserial_mac_array_if #(.LANES(4),  .DW(8),  .OW(12)) b_if ();

    bitserial_mac_array #(
        .LANES(16), .DW(16), .WW(16), .FRAC(8), .OW(16)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    bitserial_mac_array #(
        .LANES(4), .DW(8), .WW(8), .FRAC(4), .OW(12)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    typedef struct {
        string        name;
        logic [255:0] neu;
        logic [255:0] wts;
        logic [15:0]  res;
        logic         sat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rep16(input logic [15:0] x);
        return {16{x}};
    endfunction

    // Entered #1 after an edge with the DUT idle. Returns the cycle count
    // from the start edge to the edge after which out_valid is seen.
    task automatic run_op_a(input logic [255:0] neu, input logic [255:0] wts,
                            input int stall_at, input int stall_len,
                            output logic [15:0] res, output logic s,
                            output int lat);
        int n;
        a_if.neuron_in = neu;
        a_if.start     = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        lat = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                a_if.bit_valid = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    lat++;
                end
            end
            if (i == 8) begin
                check("accum/busy", {31'd0, a_if.busy}, 32'd1);
            end
            a_if.bit_valid = 1'b1;
            for (int k = 0; k < 16; k++) begin
                a_if.weight_bit[k] = wts[k*16 + i];
            end
            @(posedge clk); #1;
            lat++;
        end
        a_if.bit_valid = 1'b0;
        n = 0;
        while (!a_if.out_valid && n < 50) begin
            @(posedge clk); #1;
            lat++;
            n++;
        end
        res = a_if.result;
        s   = a_if.sat;
    endtask

    task automatic finish_op_a(input string name);
        a_if.out_ready = 1'b1;
        @(posedge clk); #1;
        a_if.out_ready = 1'b0;
        check({name, "/out_valid_clr"}, {31'd0, a_if.out_valid}, 32'd0);
        check({name, "/in_ready_set"},  {31'd0, a_if.in_ready},  32'd1);
    endtask

    task automatic run_op_b(input logic [31:0] neu, input logic [31:0] wts,
                            output logic [11:0] res, output logic s,
                            output int lat);
        int n;
        b_if.neuron_in = neu;
        b_if.start     = 1'b1;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            b_if.bit_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                b_if.weight_bit[k] = wts[k*8 + i];
            end
            @(posedge clk); #1;
            lat++;
        end
        b_if.bit_valid = 1'b0;
        n = 0;
        while (!b_if.out_valid && n < 50) begin
            @(posedge clk); #1;
            lat++;
            n++;
        end
        res = b_if.result;
        s   = b_if.sat;
        b_if.out_ready = 1'b1;
        @(posedge clk); #1;
        b_if.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, limit 200000 ns");
        $fatal(1);
    end

    initial begin
        logic [15:0] res;
        logic [11:0] res_b;
        logic        s;
        int          lat;
        logic [255:0] tmp;

        a_if.start = 1'b0; a_if.neuron_in = '0; a_if.bit_valid = 1'b0;
        a_if.weight_bit = '0; a_if.out_ready = 1'b0;
        b_if.start = 1'b0; b_if.neuron_in = '0; b_if.bit_valid = 1'b0;
        b_if.weight_bit = '0; b_if.out_ready = 1'b0;

        // Vector table: neurons/weights per lane, expected result and sat.
        vecs[0] = '{"ones_x4",      rep16(16'h0100), rep16(16'h0400), 16'h4000, 1'b0};
        vecs[1] = '{"neg_sat",      rep16(16'hA800), rep16(16'h0400), 16'h8000, 1'b1};
        vecs[2] = '{"pos_sat",      rep16(16'h5800), rep16(16'h0400), 16'h7FFF, 1'b1};
        vecs[3] = '{"neg_weight",   rep16(16'h0100), rep16(16'hFF00), 16'hF000, 1'b0};
        vecs[4] = '{"floor",        {240'd0, 16'hFFFF}, {240'd0, 16'h0080}, 16'hFFFF, 1'b0};
        tmp = '0;
        for (int k = 0; k < 16; k++) tmp[k*16 +: 16] = 16'(k * 256);
        vecs[5] = '{"ramp",         tmp, rep16(16'h0100), 16'h7800, 1'b0};
        vecs[6] = '{"min_weight",   rep16(16'h0001), rep16(16'h8000), 16'hF800, 1'b0};
        vecs[7] = '{"min_x_min",    rep16(16'h8000), rep16(16'h8000), 16'h7FFF, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset/in_ready",  {31'd0, a_if.in_ready},  32'd1);
        check("reset/busy",      {31'd0, a_if.busy},      32'd0);
        check("reset/out_valid", {31'd0, a_if.out_valid}, 32'd0);
        check("reset/result",    {16'd0, a_if.result},    32'd0);
        check("reset/sat",       {31'd0, a_if.sat},       32'd0);
        check("reset_b/in_ready", {31'd0, b_if.in_ready}, 32'd1);
        check("reset_b/result",   {20'd0, b_if.result},   32'd0);

        for (int j = 0; j < 8; j++) begin
            run_op_a(vecs[j].neu, vecs[j].wts, -1, 0, res, s, lat);
            check({vecs[j].name, "/latency"}, lat, 32'd17);
            check({vecs[j].name, "/result"}, {16'd0, res}, {16'd0, vecs[j].res});
            check({vecs[j].name, "/sat"}, {31'd0, s}, {31'd0, vecs[j].sat});
            finish_op_a(vecs[j].name);
        end

        // Stall after beat 5 for 3 cycles, then hold the result for 5 cycles
        // with a stray start pulse that must be ignored.
        run_op_a(rep16(16'h0100), rep16(16'h0400), 5, 3, res, s, lat);
        check("stall/latency", lat, 32'd20);
        check("stall/result", {16'd0, res}, 32'h4000);
        check("stall/sat", {31'd0, s}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            check("wait/out_valid", {31'd0, a_if.out_valid}, 32'd1);
            check("wait/result",    {16'd0, a_if.result},    32'h4000);
            check("wait/in_ready",  {31'd0, a_if.in_ready},  32'd0);
            a_if.start     = (c == 2);
            a_if.neuron_in = rep16(16'h5800);
            @(posedge clk); #1;
        end
        a_if.start = 1'b0;
        check("wait/out_valid_end", {31'd0, a_if.out_valid}, 32'd1);
        finish_op_a("stall");
        @(posedge clk); #1;
        check("after_wait/busy",     {31'd0, a_if.busy},     32'd0);
        check("after_wait/in_ready", {31'd0, a_if.in_ready}, 32'd1);

        // Reset after beat 7 of an operation; prior result is 0x4000.
        a_if.neuron_in = rep16(16'h5800);
        a_if.start     = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            a_if.bit_valid  = 1'b1;
            a_if.weight_bit = 16'hFFFF;
            @(posedge clk); #1;
        end
        a_if.bit_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort/in_ready",  {31'd0, a_if.in_ready},  32'd1);
        check("abort/out_valid", {31'd0, a_if.out_valid}, 32'd0);
        check("abort/result",    {16'd0, a_if.result},    32'd0);
        check("abort/busy",      {31'd0, a_if.busy},      32'd0);
        run_op_a(rep16(16'h0100), rep16(16'h0400), -1, 0, res, s, lat);
        check("post_abort/latency", lat, 32'd17);
        check("post_abort/result", {16'd0, res}, 32'h4000);
        check("post_abort/sat", {31'd0, s}, 32'd0);
        finish_op_a("post_abort");

        // Small instance: 1.0 x {1.0, 2.0, -1.0, 0.5} = 2.5 -> 0x028.
        run_op_b({4{8'h10}}, {8'h08, 8'hF0, 8'h20, 8'h10}, res_b, s, lat);
        check("small/latency", lat, 32'd9);
        check("small/result", {20'd0, res_b}, 32'h028);
        check("small/sat", {31'd0, s}, 32'd0);
        run_op_b({4{8'h7F}}, {4{8'h7F}}, res_b, s, lat);
        check("small_pos_sat/result", {20'd0, res_b}, 32'h7FF);
        check("small_pos_sat/sat", {31'd0, s}, 32'd1);
        run_op_b({4{8'h80}}, {4{8'h7F}}, res_b, s, lat);
        check("small_neg_sat/result", {20'd0, res_b}, 32'h800);
        check("small_neg_sat/sat", {31'd0, s}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
